// File: rtl/pwm_trip_guard.sv
// Output guard for a complementary PWM pair: registered pass-through,
// filtered fault and shoot-through trips, latched cause, idle-point re-arm.
module pwm_trip_guard #(
    parameter int unsigned FILT_WIDTH = 8,
    parameter logic        SAFE_A     = 1'b0,
    parameter logic        SAFE_B     = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  pwm_in_A,
    input  logic                  pwm_in_B,
    input  logic                  fault_n,
    input  logic [FILT_WIDTH-1:0] filt_len,
    input  logic [FILT_WIDTH-1:0] st_len,
    input  logic                  trip_clear,
    output logic                  pwmout_A,
    output logic                  pwmout_B,
    output logic                  trip,
    output logic [1:0]            trip_cause,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        TRIP = 2'd3
    } state_t;

    localparam logic [FILT_WIDTH-1:0] ALL1 = '1;
    localparam logic [FILT_WIDTH:0]   ONE  = (FILT_WIDTH+1)'(1);

    state_t                cur;
    state_t                nxt;
    logic                  sync1;
    logic                  fsync;
    logic [FILT_WIDTH-1:0] fcnt;
    logic [FILT_WIDTH-1:0] scnt;
    logic [FILT_WIDTH-1:0] fcnt_nxt;
    logic [FILT_WIDTH-1:0] scnt_nxt;
    logic [FILT_WIDTH:0]   f_len;
    logic [FILT_WIDTH:0]   s_len;
    logic [1:0]            cause_nxt;
    logic                  f_cond;
    logic                  s_cond;
    logic                  f_evt;
    logic                  s_evt;
    logic                  clr_ok;
    logic                  pass;

    assign state  = cur;
    assign f_cond = ~fsync;
    assign s_cond = pwm_in_A & pwm_in_B;

    // A programmed length of zero behaves as one.
    assign f_len = (filt_len == '0) ? ONE : {1'b0, filt_len};
    assign s_len = (st_len == '0) ? ONE : {1'b0, st_len};

    // Extra MSB keeps cnt+1 from wrapping when the counter is saturated.
    assign f_evt = f_cond && (({1'b0, fcnt} + ONE) >= f_len);
    assign s_evt = s_cond && (({1'b0, scnt} + ONE) >= s_len);

    assign clr_ok = (cur == TRIP) && trip_clear && fsync && !s_cond;

    always_comb begin
        nxt       = cur;
        cause_nxt = trip_cause;
        fcnt_nxt  = '0;
        scnt_nxt  = '0;
        if (f_cond) fcnt_nxt = (fcnt == ALL1) ? fcnt : fcnt + 1'b1;
        if (s_cond) scnt_nxt = (scnt == ALL1) ? scnt : scnt + 1'b1;
        if (f_evt || s_evt) begin
            nxt       = TRIP;
            cause_nxt = trip_cause | {s_evt, f_evt};
        end else begin
            unique case (cur)
                IDLE: if (enable) nxt = ARM;
                ARM: begin
                    if (!enable)
                        nxt = IDLE;
                    else if (pwm_in_A == SAFE_A && pwm_in_B == SAFE_B)
                        nxt = RUN;
                end
                RUN: if (!enable) nxt = IDLE;
                TRIP: begin
                    if (clr_ok) begin
                        cause_nxt = 2'b00;
                        fcnt_nxt  = '0;
                        scnt_nxt  = '0;
                        nxt       = enable ? ARM : IDLE;
                    end
                end
                default: nxt = IDLE;
            endcase
        end
    end

    // Both legs go safe whenever the pair overlaps, before any trip.
    assign pass = (nxt == RUN) && !s_cond;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur        <= IDLE;
            sync1      <= 1'b1;
            fsync      <= 1'b1;
            fcnt       <= '0;
            scnt       <= '0;
            trip_cause <= 2'b00;
            trip       <= 1'b0;
            pwmout_A   <= SAFE_A;
            pwmout_B   <= SAFE_B;
        end else begin
            cur        <= nxt;
            sync1      <= fault_n;
            fsync      <= sync1;
            fcnt       <= fcnt_nxt;
            scnt       <= scnt_nxt;
            trip_cause <= cause_nxt;
            trip       <= (nxt == TRIP);
            pwmout_A   <= pass ? pwm_in_A : SAFE_A;
            pwmout_B   <= pass ? pwm_in_B : SAFE_B;
        end
    end

endmodule

// File: tb/tb_pwm_trip_guard.sv
// Bench for pwm_trip_guard: directed scenarios and random traffic
// compared each cycle against a run-length reference model.
module tb_pwm_trip_guard;

    localparam int S_IDLE = 0;
    localparam int S_ARM  = 1;
    localparam int S_RUN  = 2;
    localparam int S_TRIP = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       pwm_in_A = 1'b0;
    logic       pwm_in_B = 1'b0;
    logic       fault_n = 1'b1;
    logic [7:0] filt_len = 8'd4;
    logic [7:0] st_len = 8'd3;
    logic       trip_clear = 1'b0;
    logic       pwmout_A;
    logic       pwmout_B;
    logic       trip;
    logic [1:0] trip_cause;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    // reference model
    int m_state;
    int m_cause;
    int m_a;
    int m_b;
    int m_trip;
    int fh_old;
    int fh_new;
    int frun;
    int srun;
    int ph = 0;
    int found;

    pwm_trip_guard #(.FILT_WIDTH(8), .SAFE_A(1'b0), .SAFE_B(1'b0)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pwm_in_A   (pwm_in_A),
        .pwm_in_B   (pwm_in_B),
        .fault_n    (fault_n),
        .filt_len   (filt_len),
        .st_len     (st_len),
        .trip_clear (trip_clear),
        .pwmout_A   (pwmout_A),
        .pwmout_B   (pwmout_B),
        .trip       (trip),
        .trip_cause (trip_cause),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_cause = 0;
        m_a     = 0;
        m_b     = 0;
        m_trip  = 0;
        fh_old  = 1;
        fh_new  = 1;
        frun    = 0;
        srun    = 0;
    endtask

    // One clock edge of the protection rules, using unbounded run lengths.
    task automatic model_edge();
        int fl, sl, fcond, scond, fev, sev, acc, pass;
        if (reset) begin
            model_reset();
            return;
        end
        fl    = (filt_len == 0) ? 1 : int'(filt_len);
        sl    = (st_len == 0) ? 1 : int'(st_len);
        fcond = (fh_old == 0);
        scond = (pwm_in_A && pwm_in_B);
        frun  = fcond ? frun + 1 : 0;
        srun  = scond ? srun + 1 : 0;
        fev   = fcond && (frun >= fl);
        sev   = scond && (srun >= sl);
        acc   = (m_state == S_TRIP) && trip_clear && (fh_old == 1) && !scond;
        if (fev || sev) begin
            m_state = S_TRIP;
            m_cause = m_cause | (sev * 2) | fev;
        end else if (acc) begin
            m_cause = 0;
            frun    = 0;
            srun    = 0;
            m_state = enable ? S_ARM : S_IDLE;
        end else if (m_state == S_IDLE) begin
            if (enable) m_state = S_ARM;
        end else if (m_state == S_ARM) begin
            if (!enable) m_state = S_IDLE;
            else if (!pwm_in_A && !pwm_in_B) m_state = S_RUN;
        end else if (m_state == S_RUN) begin
            if (!enable) m_state = S_IDLE;
        end
        pass   = (m_state == S_RUN) && !scond;
        m_a    = pass ? int'(pwm_in_A) : 0;
        m_b    = pass ? int'(pwm_in_B) : 0;
        m_trip = (m_state == S_TRIP);
        fh_old = fh_new;
        fh_new = int'(fault_n);
    endtask

    task automatic tick(input logic a, input logic b, input logic fn,
                        input logic en, input logic clr);
        pwm_in_A   = a;
        pwm_in_B   = b;
        fault_n    = fn;
        enable     = en;
        trip_clear = clr;
        @(posedge clk);
        model_edge();
        #1;
        chk("state", int'(state), m_state);
        chk("pwmout_A", int'(pwmout_A), m_a);
        chk("pwmout_B", int'(pwmout_B), m_b);
        chk("trip", int'(trip), m_trip);
        chk("trip_cause", int'(trip_cause), m_cause);
    endtask

    // Dead-band PWM: A high on phases 1-3, B high on 5-7, both low on 0 and 4.
    task automatic pwm_tick(input logic fn, input logic en, input logic clr);
        tick(ph inside {1, 2, 3}, ph inside {5, 6, 7}, fn, en, clr);
        ph = (ph + 1) % 8;
    endtask

    initial begin
        int burst;
        logic ra, rb, rfn, ren, rclr;
        model_reset();

        // reset state
        tick(0, 0, 1, 0, 0);
        tick(0, 0, 1, 1, 0);
        chk("rst_state", int'(state), S_IDLE);
        chk("rst_cause", int'(trip_cause), 0);
        reset = 1'b0;

        // enable with PWM: ARM then RUN, one-cycle pass-through
        for (int i = 0; i < 24; i++) pwm_tick(1, 1, 0);
        chk("run_reached", int'(state), S_RUN);

        // short fault pulse is filtered out
        for (int i = 0; i < 3; i++) pwm_tick(0, 1, 0);
        for (int i = 0; i < 6; i++) pwm_tick(1, 1, 0);
        chk("short_fault_notrip", int'(trip), 0);

        // long fault trips with cause 01
        for (int i = 0; i < 10; i++) pwm_tick(0, 1, 0);
        chk("fault_trip", int'(trip), 1);
        chk("fault_cause", int'(trip_cause), 1);
        chk("fault_safe_A", int'(pwmout_A), 0);

        // clear while synchroniser still low is dropped, later one accepted
        tick(0, 0, 1, 1, 1);
        chk("clr_dropped", int'(state), S_TRIP);
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 1, 0);
        tick(0, 0, 1, 1, 1);
        chk("clr_to_arm", int'(state), S_ARM);
        chk("clr_cause0", int'(trip_cause), 0);

        // shoot-through: short overlap gated, long overlap trips
        ph = 0;
        for (int i = 0; i < 10; i++) pwm_tick(1, 1, 0);
        tick(1, 1, 1, 1, 0);
        chk("st_gate_A", int'(pwmout_A), 0);
        tick(1, 1, 1, 1, 0);
        chk("st_short_notrip", int'(trip), 0);
        for (int i = 0; i < 8; i++) pwm_tick(1, 1, 0);
        for (int i = 0; i < 5; i++) tick(1, 1, 1, 1, 0);
        chk("st_cause", int'(trip_cause), 2);
        tick(0, 0, 1, 1, 1);
        chk("st_clr", int'(state), S_ARM);

        // fault and shoot-through reach their trip on the same edge
        ph = 0;
        for (int i = 0; i < 10; i++) pwm_tick(1, 1, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 0);
        chk("both_pre", int'(trip), 0);
        for (int i = 0; i < 3; i++) tick(1, 1, 0, 1, 0);
        chk("both_cause", int'(trip_cause), 3);
        tick(0, 0, 0, 1, 1);
        chk("both_clr_ignored", int'(state), S_TRIP);
        tick(0, 0, 0, 0, 0);
        chk("trip_ignores_en", int'(state), S_TRIP);
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 0, 0);
        tick(0, 0, 1, 0, 1);
        chk("clr_to_idle", int'(state), S_IDLE);

        // long filter: counter saturation and a 255-cycle length
        ph = 0;
        for (int i = 0; i < 12; i++) pwm_tick(1, 1, 0);
        filt_len = 8'd255;
        for (int i = 0; i < 300; i++) tick(0, 0, 0, 1, 0);
        chk("sat_trip", int'(trip), 1);
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 1, 0);
        tick(0, 0, 1, 1, 1);

        // random traffic
        burst = 0;
        for (int i = 0; i < 300; i++) begin
            if (i % 25 == 0) begin
                filt_len = 8'($urandom_range(0, 5));
                st_len   = 8'($urandom_range(0, 4));
            end
            if (burst == 0 && $urandom_range(0, 99) < 6)
                burst = $urandom_range(1, 8);
            rfn = (burst == 0);
            if (burst > 0) burst--;
            ra   = 1'($urandom_range(0, 1));
            rb   = 1'($urandom_range(0, 1));
            ren  = ($urandom_range(0, 99) < 90);
            rclr = ($urandom_range(0, 99) < 15);
            tick(ra, rb, rfn, ren, rclr);
        end

        // asynchronous reset while pwmout_A is high
        filt_len = 8'd4;
        st_len   = 8'd3;
        reset    = 1'b1;
        tick(0, 0, 1, 0, 0);
        reset = 1'b0;
        ph    = 0;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (m_state == S_RUN && m_a == 1) begin
                found = 1;
                break;
            end
            pwm_tick(1, 1, 0);
        end
        chk("find_run_high", found, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_A", int'(pwmout_A), 0);
        chk("async_rst_state", int'(state), S_IDLE);
        model_reset();
        tick(0, 0, 1, 1, 0);
        reset = 1'b0;
        tick(0, 0, 1, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
